// File: rtl/starflux_pkg.sv
// Shared Starflux constants, the per-axis direction type and its decoder.
package starflux_pkg;

  localparam int unsigned SCREEN_W      = 256;
  localparam int unsigned SCREEN_H      = 256;
  localparam int unsigned POS_W_DEFAULT = 8;
  localparam int unsigned TICK_DIV_16HZ = 3125000;
  localparam int unsigned MODE_CLAMP    = 0;
  localparam int unsigned MODE_WRAP     = 1;

  typedef enum logic [1:0] {
    DIR_NONE = 2'd0,
    DIR_INC  = 2'd1,
    DIR_DEC  = 2'd2
  } dir_e;

  // Opposing requests cancel out.
  function automatic dir_e dir_decode(input logic inc, input logic dec);
    dir_e d;
    d = DIR_NONE;
    if (inc && !dec) d = DIR_INC;
    if (dec && !inc) d = DIR_DEC;
    return d;
  endfunction

endpackage

// File: rtl/axis_stepper.sv
// One position axis: direction decode, hold counter, step select, clamp/wrap.
// Ports: clock, reset (async high), tick (move strobe), recenter, inc/dec
// (synchronised requests), pos (registered position), at_min/at_max (comb flags).
module axis_stepper
  import starflux_pkg::*;
#(
  parameter int unsigned POS_W       = POS_W_DEFAULT,
  parameter int unsigned P_MIN       = 0,
  parameter int unsigned P_MAX       = 255,
  parameter int unsigned P_INIT      = 128,
  parameter int unsigned STEP_SLOW   = 1,
  parameter int unsigned STEP_FAST   = 4,
  parameter int unsigned ACCEL_TICKS = 8,
  parameter int unsigned WRAP        = MODE_CLAMP
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             tick,
  input  logic             recenter,
  input  logic             inc,
  input  logic             dec,
  output logic [POS_W-1:0] pos,
  output logic             at_min,
  output logic             at_max
);

  localparam int unsigned EXT_W  = POS_W + 1;
  localparam int unsigned HOLD_W = $clog2(ACCEL_TICKS + 1);

  localparam logic [EXT_W-1:0]  MIN_E   = EXT_W'(P_MIN);
  localparam logic [EXT_W-1:0]  MAX_E   = EXT_W'(P_MAX);
  localparam logic [EXT_W-1:0]  SLOW_E  = EXT_W'(STEP_SLOW);
  localparam logic [EXT_W-1:0]  FAST_E  = EXT_W'(STEP_FAST);
  localparam logic [EXT_W-1:0]  ONE_E   = EXT_W'(1);
  localparam logic [HOLD_W-1:0] ACCEL_H = HOLD_W'(ACCEL_TICKS);
  localparam logic [HOLD_W-1:0] ONE_H   = HOLD_W'(1);
  localparam logic [POS_W-1:0]  INIT_P  = POS_W'(P_INIT);
  localparam logic [POS_W-1:0]  MIN_P   = POS_W'(P_MIN);
  localparam logic [POS_W-1:0]  MAX_P   = POS_W'(P_MAX);

  dir_e              dir;
  dir_e              last_dir;
  dir_e              last_dir_next;
  logic [HOLD_W-1:0] hold;
  logic [HOLD_W-1:0] hold_next;
  logic [POS_W-1:0]  pos_next;
  logic [EXT_W-1:0]  pos_e;
  logic [EXT_W-1:0]  step_e;
  logic [EXT_W-1:0]  sum_e;
  logic [EXT_W-1:0]  floor_e;

  // Position, hold count and last-tick direction registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pos      <= INIT_P;
      hold     <= '0;
      last_dir <= DIR_NONE;
    end else begin
      pos      <= pos_next;
      hold     <= hold_next;
      last_dir <= last_dir_next;
    end
  end

  // Next-state: bounded step on tick, recenter takes priority.
  always_comb begin
    dir           = dir_decode(inc, dec);
    pos_next      = pos;
    hold_next     = hold;
    last_dir_next = last_dir;
    pos_e         = {1'b0, pos};
    step_e        = (hold >= ACCEL_H) ? FAST_E : SLOW_E;
    sum_e         = pos_e + step_e;
    floor_e       = MIN_E + step_e;

    if (tick) begin
      unique case (dir)
        DIR_INC: begin
          if (sum_e > MAX_E) begin
            pos_next = (WRAP != 0) ? POS_W'(MIN_E + (sum_e - MAX_E - ONE_E)) : MAX_P;
          end else begin
            pos_next = POS_W'(sum_e);
          end
        end
        DIR_DEC: begin
          // pos < MIN+step is the underflow test, kept non-negative.
          if (pos_e < floor_e) begin
            pos_next = (WRAP != 0) ? POS_W'(MAX_E - (floor_e - pos_e - ONE_E)) : MIN_P;
          end else begin
            pos_next = POS_W'(pos_e - step_e);
          end
        end
        default: pos_next = pos;
      endcase

      if (dir == DIR_NONE) begin
        hold_next = '0;
      end else if (dir == last_dir) begin
        hold_next = (hold < ACCEL_H) ? hold + ONE_H : hold;
      end else begin
        hold_next = ONE_H;
      end
      last_dir_next = dir;
    end

    if (recenter) begin
      pos_next      = INIT_P;
      hold_next     = '0;
      last_dir_next = DIR_NONE;
    end
  end

  assign at_min = (pos == MIN_P);
  assign at_max = (pos == MAX_P);

endmodule

// File: rtl/ship_position_ctrl.sv
// Two-axis player-ship position controller: key synchronisers, move-tick
// divider and one axis_stepper per axis.
// Ports: clock, reset (async high), enable, left/right/up/down keys, recenter;
// x_val/y_val (registered), tick (move strobe), at_left/at_right/at_top/at_bottom.
module ship_position_ctrl
  import starflux_pkg::*;
#(
  parameter int unsigned POS_W       = POS_W_DEFAULT,
  parameter int unsigned TICK_DIV    = TICK_DIV_16HZ,
  parameter int unsigned X_MIN       = 0,
  parameter int unsigned X_MAX       = SCREEN_W - 1,
  parameter int unsigned Y_MIN       = 0,
  parameter int unsigned Y_MAX       = SCREEN_H - 1,
  parameter int unsigned X_INIT      = 128,
  parameter int unsigned Y_INIT      = 128,
  parameter int unsigned STEP_SLOW   = 1,
  parameter int unsigned STEP_FAST   = 4,
  parameter int unsigned ACCEL_TICKS = 8,
  parameter int unsigned WRAP        = MODE_CLAMP
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             left,
  input  logic             right,
  input  logic             up,
  input  logic             down,
  input  logic             recenter,
  output logic [POS_W-1:0] x_val,
  output logic [POS_W-1:0] y_val,
  output logic             tick,
  output logic             at_left,
  output logic             at_right,
  output logic             at_top,
  output logic             at_bottom
);

  localparam int unsigned CNT_W  = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(TICK_DIV - 1);

  // Key order: {left, right, up, down}.
  logic [3:0]       key_s1;
  logic [3:0]       key_s2;
  logic [CNT_W-1:0] div_cnt;

  // Two-flop synchronisers for the asynchronous key inputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      key_s1 <= '0;
      key_s2 <= '0;
    end else begin
      key_s1 <= {left, right, up, down};
      key_s2 <= key_s1;
    end
  end

  // Down-counting tick divider, frozen while paused.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      div_cnt <= RELOAD;
    end else if (enable) begin
      div_cnt <= (div_cnt == '0) ? RELOAD : div_cnt - CNT_W'(1);
    end
  end

  assign tick = enable && (div_cnt == '0);

  axis_stepper #(
    .POS_W(POS_W), .P_MIN(X_MIN), .P_MAX(X_MAX), .P_INIT(X_INIT),
    .STEP_SLOW(STEP_SLOW), .STEP_FAST(STEP_FAST),
    .ACCEL_TICKS(ACCEL_TICKS), .WRAP(WRAP)
  ) u_x_axis (
    .clock(clock), .reset(reset), .tick(tick), .recenter(recenter),
    .inc(key_s2[2]), .dec(key_s2[3]),
    .pos(x_val), .at_min(at_left), .at_max(at_right)
  );

  axis_stepper #(
    .POS_W(POS_W), .P_MIN(Y_MIN), .P_MAX(Y_MAX), .P_INIT(Y_INIT),
    .STEP_SLOW(STEP_SLOW), .STEP_FAST(STEP_FAST),
    .ACCEL_TICKS(ACCEL_TICKS), .WRAP(WRAP)
  ) u_y_axis (
    .clock(clock), .reset(reset), .tick(tick), .recenter(recenter),
    .inc(key_s2[0]), .dec(key_s2[1]),
    .pos(y_val), .at_min(at_top), .at_max(at_bottom)
  );

endmodule

// File: tb/tb_ship_position_ctrl.sv
// Bench for ship_position_ctrl: a clamp instance and a wrap instance share
// stimulus; a behavioural model predicts both every cycle, and directed
// scenarios pin key values with literal expectations.
module tb_ship_position_ctrl;

  localparam int TD     = 4;
  localparam int ACCEL  = 3;
  localparam int SLOW   = 1;
  localparam int FAST   = 4;
  localparam int XMIN   = 0;
  localparam int XMAX   = 255;
  localparam int YMIN   = 0;
  localparam int YMAX   = 255;
  localparam int XINIT  = 128;
  localparam int YINIT  = 128;

  logic clock, reset, enable, left, right, up, down, recenter;
  logic [7:0] x_c, y_c, x_w, y_w;
  logic tick_c, al_c, ar_c, at_c, ab_c;
  logic tick_w, al_w, ar_w, at_w, ab_w;

  int checks = 0;
  int errors = 0;

  ship_position_ctrl #(
    .POS_W(8), .TICK_DIV(TD), .X_MIN(XMIN), .X_MAX(XMAX), .Y_MIN(YMIN), .Y_MAX(YMAX),
    .X_INIT(XINIT), .Y_INIT(YINIT), .STEP_SLOW(SLOW), .STEP_FAST(FAST),
    .ACCEL_TICKS(ACCEL), .WRAP(0)
  ) dut_c (
    .clock(clock), .reset(reset), .enable(enable), .left(left), .right(right),
    .up(up), .down(down), .recenter(recenter), .x_val(x_c), .y_val(y_c),
    .tick(tick_c), .at_left(al_c), .at_right(ar_c), .at_top(at_c), .at_bottom(ab_c)
  );

  ship_position_ctrl #(
    .POS_W(8), .TICK_DIV(TD), .X_MIN(XMIN), .X_MAX(XMAX), .Y_MIN(YMIN), .Y_MAX(YMAX),
    .X_INIT(XINIT), .Y_INIT(YINIT), .STEP_SLOW(SLOW), .STEP_FAST(FAST),
    .ACCEL_TICKS(ACCEL), .WRAP(1)
  ) dut_w (
    .clock(clock), .reset(reset), .enable(enable), .left(left), .right(right),
    .up(up), .down(down), .recenter(recenter), .x_val(x_w), .y_val(y_w),
    .tick(tick_w), .at_left(al_w), .at_right(ar_w), .at_top(at_w), .at_bottom(ab_w)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Index [m][ax]: m=0 clamp, m=1 wrap; ax=0 x, ax=1 y.
  int mpos  [2][2];
  int mhold [2][2];
  int mlast [2][2];
  int en_cnt;
  logic [3:0] ka, kb, use_k;
  bit  mtick;
  int  mdir [2];
  int  np, stp, lo, hi;

  function automatic int amin(input int ax); return (ax == 0) ? XMIN : YMIN; endfunction
  function automatic int amax(input int ax); return (ax == 0) ? XMAX : YMAX; endfunction
  function automatic int ainit(input int ax); return (ax == 0) ? XINIT : YINIT; endfunction

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int m = 0; m < 2; m++)
        for (int ax = 0; ax < 2; ax++) begin
          mpos[m][ax] = ainit(ax); mhold[m][ax] = 0; mlast[m][ax] = 0;
        end
      ka = '0; kb = '0; en_cnt = 0;
    end else begin
      // Keys reach the movement logic two edges after they are sampled.
      use_k = kb; kb = ka; ka = {left, right, up, down};
      mtick = enable && (en_cnt % TD == TD - 1);
      if (enable) en_cnt++;
      mdir[0] = (use_k[2] && !use_k[3]) ? 1 : (use_k[3] && !use_k[2]) ? -1 : 0;
      mdir[1] = (use_k[0] && !use_k[1]) ? 1 : (use_k[1] && !use_k[0]) ? -1 : 0;
      for (int m = 0; m < 2; m++)
        for (int ax = 0; ax < 2; ax++) begin
          lo = amin(ax); hi = amax(ax);
          if (recenter) begin
            mpos[m][ax] = ainit(ax); mhold[m][ax] = 0; mlast[m][ax] = 0;
          end else if (mtick) begin
            stp = (mhold[m][ax] >= ACCEL) ? FAST : SLOW;
            np  = mpos[m][ax];
            if (mdir[ax] == 1) begin
              np = np + stp;
              if (np > hi) np = (m == 1) ? lo + (np - hi - 1) : hi;
            end else if (mdir[ax] == -1) begin
              np = np - stp;
              if (np < lo) np = (m == 1) ? hi - (lo - np - 1) : lo;
            end
            mpos[m][ax] = np;
            if (mdir[ax] == 0) mhold[m][ax] = 0;
            else if (mdir[ax] == mlast[m][ax]) mhold[m][ax] = (mhold[m][ax] + 1 > ACCEL) ? ACCEL : mhold[m][ax] + 1;
            else mhold[m][ax] = 1;
            mlast[m][ax] = mdir[ax];
          end
        end
    end
  end

  // Every-cycle comparison of both instances against the model.
  always @(negedge clock) begin
    int et;
    et = (enable && (en_cnt % TD == TD - 1)) ? 1 : 0;
    chk("cyc_x_c", int'(x_c), mpos[0][0]);
    chk("cyc_y_c", int'(y_c), mpos[0][1]);
    chk("cyc_x_w", int'(x_w), mpos[1][0]);
    chk("cyc_y_w", int'(y_w), mpos[1][1]);
    chk("cyc_tick_c", int'(tick_c), et);
    chk("cyc_tick_w", int'(tick_w), et);
    chk("cyc_at_left_c",   int'(al_c), int'(mpos[0][0] == XMIN));
    chk("cyc_at_right_c",  int'(ar_c), int'(mpos[0][0] == XMAX));
    chk("cyc_at_top_c",    int'(at_c), int'(mpos[0][1] == YMIN));
    chk("cyc_at_bottom_c", int'(ab_c), int'(mpos[0][1] == YMAX));
    chk("cyc_at_left_w",   int'(al_w), int'(mpos[1][0] == XMIN));
    chk("cyc_at_right_w",  int'(ar_w), int'(mpos[1][0] == XMAX));
    chk("cyc_at_top_w",    int'(at_w), int'(mpos[1][1] == YMIN));
    chk("cyc_at_bottom_w", int'(ab_w), int'(mpos[1][1] == YMAX));
  end

  // ---------------- stimulus helpers ----------------
  function automatic int dut_pos(input int m, input int ax);
    if (m == 0) return (ax == 0) ? int'(x_c) : int'(y_c);
    return (ax == 0) ? int'(x_w) : int'(y_w);
  endfunction

  task automatic set_keys(input logic l, input logic r, input logic u, input logic d);
    #1;
    left = l; right = r; up = u; down = d;
  endtask

  task automatic set_dir(input int ax, input int d);
    if (ax == 0) set_keys(d < 0, d > 0, 1'b0, 1'b0);
    else         set_keys(1'b0, 1'b0, d < 0, d > 0);
  endtask

  // Wait for n ticks; returns at the falling edge after each tick's move edge.
  task automatic tick_wait(input int n);
    for (int i = 0; i < n; i++) begin
      int guard;
      guard = 0;
      do begin
        @(negedge clock);
        guard++;
      end while (!tick_c && guard < 20);
      if (!tick_c) chk("tick_timeout", 0, 1);
      @(negedge clock);
    end
  endtask

  task automatic recenter_pulse();
    #1 recenter = 1'b1;
    @(negedge clock);
    #1 recenter = 1'b0;
  endtask

  // Navigate instance m's axis to target using the model position; leaves hold at 0.
  task automatic goto_pos(input int m, input int ax, input int target);
    int guard;
    guard = 0;
    while (mpos[m][ax] != target && guard < 300) begin
      int d;
      d = target - mpos[m][ax];
      guard++;
      if (d >= 12 || d <= -12) begin
        set_dir(ax, (d > 0) ? 1 : -1);
        tick_wait(1);
      end else begin
        set_dir(ax, 0);
        tick_wait(1);
        set_dir(ax, (d > 0) ? 1 : -1);
        tick_wait(1);
        set_dir(ax, 0);
      end
    end
    set_dir(ax, 0);
    tick_wait(1);
    chk("goto_reached", dut_pos(m, ax), target);
  endtask

  int exp_list [$];
  int cyc;

  initial begin
    if (!(TD >= 2 && XMIN <= XINIT && XINIT <= XMAX && YMIN <= YINIT && YINIT <= YMAX &&
          FAST <= XMAX - XMIN && FAST <= YMAX - YMIN)) begin
      $display("FAIL param_legality");
      $fatal(1, "illegal bench parameters");
    end
    reset = 1'b1; enable = 1'b1; recenter = 1'b0;
    left = 1'b0; right = 1'b0; up = 1'b0; down = 1'b0;
    repeat (3) @(negedge clock);
    #1 reset = 1'b0;

    // 1. async reset mid-period with right held, then first move is slow
    set_dir(0, 1);
    tick_wait(2);
    @(posedge clock);
    #2 reset = 1'b1;
    #1;
    chk("rst_x", int'(x_c), 128);
    chk("rst_y", int'(y_c), 128);
    chk("rst_tick", int'(tick_c), 0);
    chk("rst_x_w", int'(x_w), 128);
    @(negedge clock);
    #1 reset = 1'b0;
    tick_wait(1);
    chk("rst_first_step", int'(x_c), 129);
    set_dir(0, 0);
    tick_wait(1);

    // 2. clamp at right and top bounds
    goto_pos(0, 0, 254);
    set_dir(0, 1);
    tick_wait(1); chk("clamp_x_1", int'(x_c), 255);
    tick_wait(1); chk("clamp_x_2", int'(x_c), 255); chk("clamp_at_right", int'(ar_c), 1);
    tick_wait(1); chk("clamp_x_3", int'(x_c), 255);
    set_dir(0, 0);
    goto_pos(0, 1, 1);
    set_dir(1, -1);
    tick_wait(1); chk("clamp_y_1", int'(y_c), 0);
    tick_wait(1); chk("clamp_y_2", int'(y_c), 0); chk("clamp_at_top", int'(at_c), 1);
    set_dir(1, 0);
    tick_wait(1);

    // 3. acceleration, release/re-press, reversal
    recenter_pulse();
    goto_pos(0, 0, 100);
    set_dir(0, 1);
    exp_list = '{101, 102, 103, 107, 111};
    foreach (exp_list[i]) begin
      tick_wait(1);
      chk("accel_x", int'(x_c), exp_list[i]);
    end
    set_dir(0, 0); tick_wait(1); chk("accel_release", int'(x_c), 111);
    set_dir(0, 1); tick_wait(1); chk("accel_repress", int'(x_c), 112);
    set_dir(0, -1); tick_wait(1); chk("accel_reverse", int'(x_c), 111);
    set_dir(0, 0); tick_wait(1);

    // 4. wrap instance
    recenter_pulse();
    goto_pos(1, 0, 0);
    set_dir(0, -1); tick_wait(1); chk("wrap_x_under", int'(x_w), 255);
    set_dir(0, 0); tick_wait(1);
    goto_pos(1, 0, 251);
    set_dir(0, 1);
    exp_list = '{252, 253, 254, 2};
    foreach (exp_list[i]) begin
      tick_wait(1);
      chk("wrap_x_over", int'(x_w), exp_list[i]);
    end
    set_dir(0, 0); tick_wait(1);
    goto_pos(1, 1, 4);
    set_dir(1, -1);
    exp_list = '{3, 2, 1, 253};
    foreach (exp_list[i]) begin
      tick_wait(1);
      chk("wrap_y_under", int'(y_w), exp_list[i]);
    end
    set_dir(1, 0); tick_wait(1);

    // 5. opposing keys cancel and reset hold; pause freezes everything
    recenter_pulse();
    set_dir(0, 1);
    exp_list = '{129, 130, 131, 135};
    foreach (exp_list[i]) begin
      tick_wait(1);
      chk("both_pre", int'(x_c), exp_list[i]);
    end
    set_keys(1'b1, 1'b1, 1'b0, 1'b0); tick_wait(1); chk("both_hold_x", int'(x_c), 135);
    set_dir(0, 1); tick_wait(1); chk("both_after_slow", int'(x_c), 136);
    @(negedge clock);
    #1 enable = 1'b0;
    repeat (7) begin
      @(negedge clock);
      chk("pause_tick", int'(tick_c), 0);
    end
    chk("pause_x", int'(x_c), 136);
    #1 enable = 1'b1;
    cyc = 0;
    do begin
      @(negedge clock);
      cyc++;
    end while (!tick_c && cyc < 20);
    chk("pause_resume_cycles", cyc, 2);
    @(negedge clock);
    chk("pause_resume_x", int'(x_c), 137);

    // 6. recenter coincident with a tick while moving
    set_dir(0, 0);
    recenter_pulse();
    set_dir(0, 1);
    tick_wait(2);
    cyc = 0;
    do begin
      @(negedge clock);
      cyc++;
    end while (!tick_c && cyc < 20);
    chk("rc_saw_tick", int'(tick_c), 1);
    #1 recenter = 1'b1;
    @(negedge clock);
    chk("rc_x", int'(x_c), 128);
    #1 recenter = 1'b0;
    cyc = 1;
    while (!tick_c && cyc < 20) begin
      @(negedge clock);
      cyc++;
    end
    chk("rc_period", cyc, 4);

    // random stimulus checked by the model
    set_keys(1'b0, 1'b0, 1'b0, 1'b0);
    recenter_pulse();
    repeat (3000) begin
      @(negedge clock);
      #1;
      if ($urandom_range(7) == 0) {left, right, up, down} = 4'($urandom);
      enable   = ($urandom_range(9) != 0);
      recenter = ($urandom_range(199) == 0);
    end
    @(negedge clock);
    #1 enable = 1'b1; recenter = 1'b0;
    repeat (4) @(negedge clock);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
